// File: rtl/demux1x2_32bit_buf.sv
// demux1x2_32bit_buf: steers one source to port a (select=1) or port b (select=0),
// each destination buffered by a small valid/ready FIFO.
module demux1x2_32bit_buf #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [WIDTH-1:0]           in_data,
  input  logic                       in_select,
  input  logic                       in_valid,
  output logic                       in_ready,
  output logic [WIDTH-1:0]           a_data,
  output logic                       a_valid,
  input  logic                       a_ready,
  output logic [WIDTH-1:0]           b_data,
  output logic                       b_valid,
  input  logic                       b_ready,
  output logic [$clog2(DEPTH+1)-1:0] a_count,
  output logic [$clog2(DEPTH+1)-1:0] b_count
);
  localparam int CW = $clog2(DEPTH+1);
  localparam int PW = $clog2(DEPTH);
  logic [1:0]            w_sel, w_rdy, w_push, w_pop, w_valid, w_full;
  logic [1:0][CW-1:0]    w_cnt;
  logic [1:0][WIDTH-1:0] w_head;
  // Index 0 is port a, index 1 is port b.
  assign w_sel    = {~in_select, in_select};
  assign w_rdy    = {b_ready, a_ready};
  assign in_ready = |(w_sel & ~w_full);
  assign w_push   = w_sel & {2{in_valid & in_ready}};
  assign w_pop    = w_valid & w_rdy;
  for (genvar g = 0; g < 2; g++) begin : g_fifo
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wp, r_rp;
    logic [CW-1:0]    r_cnt;
    // Storage needs no reset: the head is masked whenever the FIFO is empty.
    always_ff @(posedge clk)
      if (w_push[g]) r_mem[r_wp] <= in_data;
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        r_wp  <= '0;
        r_rp  <= '0;
        r_cnt <= '0;
      end else begin
        r_wp  <= r_wp + PW'(w_push[g]);
        r_rp  <= r_rp + PW'(w_pop[g]);
        r_cnt <= r_cnt + CW'(w_push[g]) - CW'(w_pop[g]);
      end
    end
    assign w_valid[g] = r_cnt != '0;
    assign w_full[g]  = r_cnt == CW'(DEPTH);
    assign w_cnt[g]   = r_cnt;
    assign w_head[g]  = w_valid[g] ? r_mem[r_rp] : '0;
  end
  assign a_data  = w_head[0];
  assign b_data  = w_head[1];
  assign a_valid = w_valid[0];
  assign b_valid = w_valid[1];
  assign a_count = w_cnt[0];
  assign b_count = w_cnt[1];
endmodule

// File: tb/tb_demux1x2_32bit_buf.sv
// tb_demux1x2_32bit_buf: table-driven and scoreboard checks of the 1:2 buffered demux.
module tb_demux1x2_32bit_buf;
  logic        clk = 0;
  logic        rst = 0;
  logic [31:0] in_data = '0;
  logic        in_select = 0, in_valid = 0, in_ready;
  logic [31:0] a_data, b_data;
  logic        a_valid, b_valid, a_ready = 0, b_ready = 0;
  logic [1:0]  a_count, b_count;
  int          errors = 0, checks = 0;
  logic [31:0] qa[$], qb[$];
  logic        acc, popb;
  logic [31:0] last_bd;

  demux1x2_32bit_buf dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_select(in_select),
    .in_valid(in_valid), .in_ready(in_ready), .a_data(a_data), .a_valid(a_valid),
    .a_ready(a_ready), .b_data(b_data), .b_valid(b_valid), .b_ready(b_ready),
    .a_count(a_count), .b_count(b_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic chk_outs();
    chk("a_valid", 32'(a_valid), 32'(qa.size() != 0));
    chk("a_data", a_data, qa.size() != 0 ? qa[0] : 32'h0);
    chk("a_count", 32'(a_count), 32'(qa.size()));
    chk("b_valid", 32'(b_valid), 32'(qb.size() != 0));
    chk("b_data", b_data, qb.size() != 0 ? qb[0] : 32'h0);
    chk("b_count", 32'(b_count), 32'(qb.size()));
    chk("in_ready", 32'(in_ready), 32'(in_select ? qa.size() < 2 : qb.size() < 2));
  endtask

  // One cycle: drive, check outputs against the scoreboard, update model, clock.
  task automatic cyc(input logic v, input logic sel, input logic [31:0] d,
                     input logic ar, input logic br);
    logic popa;
    in_valid = v; in_select = sel; in_data = d; a_ready = ar; b_ready = br;
    #1;
    chk_outs();
    last_bd = b_data;
    acc  = v && (sel ? qa.size() < 2 : qb.size() < 2);
    popa = ar && qa.size() != 0;
    popb = br && qb.size() != 0;
    if (popa) void'(qa.pop_front());
    if (popb) void'(qb.pop_front());
    if (acc) begin
      if (sel) qa.push_back(d);
      else     qb.push_back(d);
    end
    @(posedge clk); #1;
  endtask

  typedef struct packed {
    logic        v, sel;
    logic [31:0] d;
    logic        ar, br;
    logic [1:0]  ea, eb;
  } vec_t;
  vec_t tbl [18];

  initial begin
    int nxt, got;
    tbl[0]  = '{1'b1, 1'b1, 32'hDEADBEEF, 1'b0, 1'b0, 2'd1, 2'd0};
    tbl[1]  = '{1'b1, 1'b0, 32'h12345678, 1'b0, 1'b0, 2'd1, 2'd1};
    tbl[2]  = '{1'b0, 1'b1, 32'h0,        1'b0, 1'b0, 2'd1, 2'd1};
    tbl[3]  = '{1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 2'd0, 2'd0};
    tbl[4]  = '{1'b1, 1'b1, 32'h1,        1'b0, 1'b0, 2'd1, 2'd0};
    tbl[5]  = '{1'b1, 1'b1, 32'h2,        1'b0, 1'b0, 2'd2, 2'd0};
    tbl[6]  = '{1'b1, 1'b1, 32'h3,        1'b0, 1'b0, 2'd2, 2'd0};
    tbl[7]  = '{1'b1, 1'b1, 32'h3,        1'b0, 1'b0, 2'd2, 2'd0};
    tbl[8]  = '{1'b1, 1'b0, 32'h3,        1'b0, 1'b0, 2'd2, 2'd1};
    tbl[9]  = '{1'b1, 1'b1, 32'h4,        1'b1, 1'b0, 2'd1, 2'd1};
    tbl[10] = '{1'b0, 1'b1, 32'h0,        1'b1, 1'b1, 2'd0, 2'd0};
    tbl[11] = '{1'b1, 1'b1, 32'hA,        1'b0, 1'b0, 2'd1, 2'd0};
    tbl[12] = '{1'b1, 1'b1, 32'hB,        1'b1, 1'b0, 2'd1, 2'd0};
    tbl[13] = '{1'b0, 1'b1, 32'h0,        1'b0, 1'b0, 2'd1, 2'd0};
    tbl[14] = '{1'b0, 1'b1, 32'h0,        1'b1, 1'b0, 2'd0, 2'd0};
    tbl[15] = '{1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 2'd0, 2'd0};
    tbl[16] = '{1'b0, 1'b1, 32'h0,        1'b1, 1'b1, 2'd0, 2'd0};
    tbl[17] = '{1'b0, 1'b0, 32'hFFFFFFFF, 1'b1, 1'b1, 2'd0, 2'd0};

    repeat (2) @(posedge clk);
    #1;
    chk_outs();
    rst = 1;
    @(posedge clk); #1;

    for (int i = 0; i < 18; i++) begin
      cyc(tbl[i].v, tbl[i].sel, tbl[i].d, tbl[i].ar, tbl[i].br);
      chk($sformatf("tbl%0d_a_count", i), 32'(a_count), 32'(tbl[i].ea));
      chk($sformatf("tbl%0d_b_count", i), 32'(b_count), 32'(tbl[i].eb));
    end

    // Asynchronous reset while FIFO a is full.
    cyc(1, 1, 32'h55, 0, 0);
    cyc(1, 1, 32'h66, 0, 0);
    chk("pre_rst_a_count", 32'(a_count), 32'd2);
    in_valid = 1; in_select = 1; in_data = 32'h77;
    #3 rst = 0;
    #1;
    chk("rst_a_valid", 32'(a_valid), 32'd0);
    chk("rst_a_data", a_data, 32'h0);
    chk("rst_a_count", 32'(a_count), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    qa.delete(); qb.delete();
    @(posedge clk); #2 rst = 1;
    cyc(0, 1, 32'h0, 0, 0);
    cyc(0, 0, 32'h0, 0, 0);
    cyc(0, 1, 32'h0, 0, 0);

    // Stream through port b with a toggling sink to exercise pointer wrap.
    nxt = 0; got = 0;
    for (int c = 0; c < 200 && (nxt < 16 || qb.size() != 0); c++) begin
      cyc(nxt < 16, 0, 32'h100 + 32'(nxt), 0, (c % 2) == 0);
      if (acc) nxt++;
      if (popb) begin
        chk("wrap_order", last_bd, 32'h100 + 32'(got));
        got++;
      end
    end
    chk("wrap_sent", 32'(nxt), 32'd16);
    chk("wrap_recv", 32'(got), 32'd16);
    cyc(0, 0, 32'h0, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/demux1x2_32bit_buf.md
Name: demux1x2_32bit_buf

Overview:
- 1-to-2 routing block: the reverse of the 2:1 datapath select. One 32-bit source is steered to one of two destinations.
- Each destination has a small FIFO with a valid/ready handshake, so a stalled consumer does not lose data.
- Used wherever a single producer feeds two datapath sinks, e.g. write-back vs. memory-store paths in the KGP_RISC core.
- Select encoding matches the existing 2:1 mux: select=1 routes to port a, select=0 routes to port b.

Parameters:
- WIDTH, 32, data width of every data port.
- DEPTH, 2, entries per output FIFO. Must be a power of two and at least 2.

Ports:
- clk  in  1  system clock; rising edge.
- rst  in  1  asynchronous, active-low reset.
- in_data  in  WIDTH  source data.
- in_select  in  1  destination: 1 = port a, 0 = port b.
- in_valid  in  1  source has a word this cycle.
- in_ready  out  1  selected destination FIFO can accept.
- a_data  out  WIDTH  head of FIFO a; 0 when a_valid=0.
- a_valid  out  1  FIFO a non-empty.
- a_ready  in  1  sink a consumes head this cycle.
- b_data  out  WIDTH  head of FIFO b; 0 when b_valid=0.
- b_valid  out  1  FIFO b non-empty.
- b_ready  in  1  sink b consumes head this cycle.
- a_count  out  clog2(DEPTH+1)  occupancy of FIFO a.
- b_count  out  clog2(DEPTH+1)  occupancy of FIFO b.

Behaviour:
- Reset (rst=0, asynchronous): read/write pointers and counts go to 0, a_valid=b_valid=0, a_data=b_data=0. in_ready then follows the empty FIFOs (=1). Reset mid-transfer discards all stored words; no partial state survives.
- in_ready is combinational: in_select ? (a_count!=DEPTH) : (b_count!=DEPTH). It depends only on occupancy and in_select, never on a_ready/b_ready.
- Push: in_valid && in_ready at a rising edge writes in_data into the selected FIFO only. The other FIFO is untouched.
- Pop: x_valid && x_ready at a rising edge advances FIFO x read pointer. x_ready while x_valid=0 is ignored.
- Latency: a word accepted at edge N is visible on x_data with x_valid=1 after edge N, i.e. in cycle N+1. There is no combinational bypass from in_data to the outputs.
- Ordering: FIFO order is preserved per port. There is no ordering relation between ports.
- Simultaneous push and pop on the same non-full FIFO: both occur, count unchanged, data stays correct (including DEPTH=2, count=1).
- Full FIFO: in_ready=0 for that select even if the same-cycle pop would free a slot (no full-cycle pass-through). The source must hold in_data/in_select/in_valid stable until accepted.
- Full on one port does not block the other: changing in_select to the non-full port raises in_ready in the same cycle.
- Pointers wrap modulo DEPTH. Counts saturate naturally and never exceed DEPTH or underflow below 0.
- in_valid=0: no write, regardless of in_select or in_ready.
- x_data output: mux of FIFO head gated by x_valid, so empty always reads 0.

Test Plan:
- Reset: assert rst=0 mid-operation with a_count=2 -> immediately a_valid=0, a_data=0, a_count=0, in_ready=1; after release, state is unchanged until the next push.
- Routing: push 0xDEADBEEF with select=1, then 0x12345678 with select=0, both sinks ready=0 -> a_data=0xDEADBEEF, a_count=1; b_data=0x12345678, b_count=1; each valid one cycle after its push.
- Full/backpressure: select=1, a_ready=0, push 0x1, 0x2, 0x3 -> 0x1 and 0x2 accepted, a_count=2, in_ready=0 while 0x3 is held. Switch select=0 -> in_ready=1 and 0x3 lands in FIFO b.
- Simultaneous push/pop: a_count=1 holding 0xA; push 0xB (select=1) with a_ready=1 in the same cycle -> next cycle a_data=0xB, a_count=1.
- Wrap-around: stream 0x100..0x10F into port b with b_ready toggling 1/0 each cycle -> b sink sees exactly 0x100..0x10F in order, no drops or duplicates, b_count never exceeds 2.
- Idle/spurious: in_valid=0 with select toggling, and a_ready=1 on an empty FIFO -> counts stay 0, outputs stay 0.
